// File: rtl/lfsr_rng_if.sv
// Draw handshake between a requester and lfsr_rng: request, busy, and the
// registered result with its valid/fail qualifiers.
interface lfsr_rng_if #(
    parameter int unsigned OUT_W = 3
);
    logic             req;
    logic             busy;
    logic [OUT_W-1:0] rnd;
    logic             rnd_valid;
    logic             rnd_fail;

    modport master (
        output req,
        input  busy,
        input  rnd,
        input  rnd_valid,
        input  rnd_fail
    );

    modport slave (
        input  req,
        output busy,
        output rnd,
        output rnd_valid,
        output rnd_fail
    );
endinterface

// File: rtl/lfsr_rng.sv
// Maximal-length XNOR Fibonacci LFSR with a bounded draw port (rejection sampling).
// Optional all-ones lock-up recovery is enabled by defining LFSR_LOCKUP_RECOVER_EN.
module lfsr_rng #(
    parameter int unsigned       WIDTH     = 10,
    parameter logic [WIDTH-1:0]  TAPS      = 10'b10_0100_0000,
    parameter longint unsigned   RANGE     = 6,
    parameter int unsigned       MAX_TRIES = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] seed_in_i,
    output logic [WIDTH-1:0] state_o,
    output logic             lockup_o,
    lfsr_rng_if.slave        draw_if
);

    localparam int unsigned OUT_W = $clog2(RANGE);
    localparam int unsigned CNT_W = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;

    // Elaboration-time parameter sanity.
    if (WIDTH < 3 || WIDTH > 32) begin : g_chk_width
        $error("lfsr_rng: WIDTH must be in 3..32");
    end
    if (RANGE < 2 || RANGE > (64'(1) << WIDTH)) begin : g_chk_range
        $error("lfsr_rng: RANGE must be in 2..2**WIDTH");
    end
    if (MAX_TRIES < 1) begin : g_chk_tries
        $error("lfsr_rng: MAX_TRIES must be at least 1");
    end
    if (OUT_W > WIDTH) begin : g_chk_outw
        $error("lfsr_rng: draw width exceeds LFSR width");
    end

    typedef enum logic {
        IDLE = 1'b0,
        DRAW = 1'b1
    } fsm_e;

    fsm_e             fsm_q;
    logic [WIDTH-1:0] state_q;
    logic [WIDTH-1:0] state_d;
    logic [CNT_W-1:0] try_q;
    logic [OUT_W-1:0] rnd_q;
    logic             rnd_valid_q;
    logic             rnd_fail_q;

    logic             fb_c;
    logic             step_c;
    logic [WIDTH-1:0] shift_c;
    logic [OUT_W-1:0] cand_c;
    logic             cand_ok_c;
    logic             last_try_c;

    assign fb_c       = ~^(state_q & TAPS);
    assign shift_c    = {state_q[WIDTH-2:0], fb_c};
    assign step_c     = en_i | (fsm_q == DRAW);
    assign cand_c     = state_q[OUT_W-1:0];
    assign cand_ok_c  = 64'(cand_c) < RANGE;
    assign last_try_c = (try_q == CNT_W'(MAX_TRIES - 1));

`ifdef LFSR_LOCKUP_RECOVER_EN
    logic lockup_d;
    logic lockup_q;

    // Next LFSR value: load wins, all-ones escapes to zero on a step.
    always_comb begin
        state_d  = state_q;
        lockup_d = 1'b0;
        if (load_i) begin
            state_d = seed_in_i;
        end else if (step_c) begin
            if (&state_q) begin
                state_d  = '0;
                lockup_d = 1'b1;
            end else begin
                state_d = shift_c;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lockup_q <= 1'b0;
        end else begin
            lockup_q <= lockup_d;
        end
    end

    assign lockup_o = lockup_q;
`else
    // Next LFSR value: load wins over step; all-ones maps onto itself.
    always_comb begin
        state_d = state_q;
        if (load_i) begin
            state_d = seed_in_i;
        end else if (step_c) begin
            state_d = shift_c;
        end
    end

    assign lockup_o = 1'b0;
`endif

    // LFSR register and draw FSM with registered result.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= '0;
            fsm_q       <= IDLE;
            try_q       <= '0;
            rnd_q       <= '0;
            rnd_valid_q <= 1'b0;
            rnd_fail_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            rnd_valid_q <= 1'b0;
            rnd_fail_q  <= 1'b0;
            unique case (fsm_q)
                IDLE: begin
                    if (draw_if.req) begin
                        fsm_q <= DRAW;
                        try_q <= '0;
                    end
                end
                DRAW: begin
                    if (cand_ok_c) begin
                        rnd_q       <= cand_c;
                        rnd_valid_q <= 1'b1;
                        fsm_q       <= IDLE;
                    end else if (last_try_c) begin
                        rnd_q       <= '0;
                        rnd_valid_q <= 1'b1;
                        rnd_fail_q  <= 1'b1;
                        fsm_q       <= IDLE;
                    end else begin
                        try_q <= try_q + CNT_W'(1);
                    end
                end
            endcase
        end
    end

    assign state_o           = state_q;
    assign draw_if.busy      = (fsm_q == DRAW);
    assign draw_if.rnd       = rnd_q;
    assign draw_if.rnd_valid = rnd_valid_q;
    assign draw_if.rnd_fail  = rnd_fail_q;

endmodule
